constraint_eval_pipe: RTL and testbench
=======================================

CONSTRAINT_EVAL_PIPE -- requirements
Module: constraint_eval_pipe

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of constrained variable channels (2..32).
REQ-002 SHALL have parameter VAR_W, default 32: width of each channel variable (1..64).
REQ-003 SHALL have parameter CNT_W, default 16: width of the pass/fail statistics counters.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port cfg_we, input, 1: mode-register write strobe.
REQ-007 SHALL have port cfg_ch, input, $clog2(NUM_CH): channel selected for the mode write.
REQ-008 SHALL have port cfg_mode, input, 2: constraint mode written to channel cfg_ch.
REQ-009 SHALL have port clr_cnt, input, 1: synchronous clear of both counters.
REQ-010 SHALL have port in_valid, input, 1: candidate assignment present.
REQ-011 SHALL have port in_ready, output, 1: candidate accepted when in_valid && in_ready.
REQ-012 SHALL have port in_data, input, NUM_CH*VAR_W: channel k occupies bits [k*VAR_W +: VAR_W].
REQ-013 SHALL have port out_valid, output, 1: verdict present.
REQ-014 SHALL have port out_ready, input, 1: verdict consumed when out_valid && out_ready.
REQ-015 SHALL have port out_sat, output, 1: 1 = all channels meet their constraints.
REQ-016 SHALL have port out_fail_idx, output, $clog2(NUM_CH): lowest failing channel index; 0 when out_sat=1.
REQ-017 SHALL have port pass_cnt, output, CNT_W: count of consumed verdicts with out_sat=1.
REQ-018 SHALL have port fail_cnt, output, CNT_W: count of consumed verdicts with out_sat=0.

Function
REQ-019 SHALL evaluate each channel per its 2-bit mode: NONZERO(00) = value != 0; ZERO(01) = value == 0; ODD(10) = XOR-reduce of value is 1; ONES(11) = all bits 1.
REQ-020 SHALL update the mode of channel cfg_ch on the edge at which cfg_we=1; the new mode applies only to beats accepted on later cycles; an out-of-range cfg_ch is ignored.
REQ-021 SHALL run a 2-stage pipeline: S1 registers the per-channel pass vector at acceptance; S2 registers out_sat (AND of the vector) and out_fail_idx (priority encode of the lowest zero).
REQ-022 SHALL present the verdict exactly 2 cycles after acceptance when out_ready is held high, and sustain 1 beat/cycle.
REQ-023 SHALL drive in_ready = !out_valid || out_ready; the whole pipeline advances together, and S1 may hold a bubble.
REQ-024 SHALL hold out_valid, out_sat and out_fail_idx stable while out_valid && !out_ready.
REQ-025 SHALL increment exactly one counter per consumed verdict; counters saturate at 2^CNT_W-1 and never wrap.
REQ-026 SHALL give clr_cnt priority: when clr_cnt coincides with a consume, both counters become 0 and that beat is not counted.
REQ-027 SHALL ignore in_data while in_valid=0, and SHALL never produce a verdict for an unaccepted beat.

Reset
REQ-028 SHALL on rst_n low immediately set in_ready=0 (while in reset) and out_valid=0, out_sat=0, out_fail_idx=0, pass_cnt=0, fail_cnt=0, all modes=NONZERO, and both pipeline valids=0.
REQ-029 SHALL discard any in-flight beats on reset mid-operation; in_ready rises on the first clock after rst_n deasserts.

Structure
REQ-030 SHALL take the mode enum (NONZERO/ZERO/ODD/ONES) and mode width from a shared package constraint_pkg.
REQ-031 SHALL implement per-channel evaluation in the combinational sub-module constraint_lane (VAR_W parameter, value + mode in, pass out), instantiated NUM_CH times.

Verification (NUM_CH=4, VAR_W=8, CNT_W=4)
REQ-032 SHALL verify: after reset, all modes NONZERO, in_data=0x01_02_03_04 -> out_sat=1 two cycles later, pass_cnt=1.
REQ-033 SHALL verify: in_data=0x05_00_07_00 -> out_sat=0, out_fail_idx=0, fail_cnt=1.
REQ-034 SHALL verify: cfg ch2=ONES, ch0=ZERO, in_data=0x01_FF_01_00 -> out_sat=1; the same write issued in the same cycle as an earlier beat does not affect that beat.
REQ-035 SHALL verify: hold out_ready=0 for 5 cycles with 3 beats offered -> at most 2 accepted, outputs stable, no loss or duplication after release.
REQ-036 SHALL verify: 17 passing beats -> pass_cnt=15 (saturated); clr_cnt coincident with a consume -> both counters read 0.
REQ-037 SHALL verify: assert rst_n low with 2 beats in flight -> out_valid=0 at once, and no stale verdict appears after release.

Source files
------------

// File: rtl/constraint_pkg.sv
// Shared constraint-mode definitions for the constraint evaluation pipeline.
// Each channel carries a 2-bit mode that selects the predicate applied to its value.
package constraint_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        NONZERO = 2'b00,
        ZERO    = 2'b01,
        ODD     = 2'b10,
        ONES    = 2'b11
    } mode_e;

endpackage

// File: rtl/constraint_lane.sv
// Single-channel constraint check: purely combinational predicate on one value.
// A separate lane per channel keeps the per-channel logic small and independent.
module constraint_lane
    import constraint_pkg::*;
#(
    parameter int VAR_W = 32
) (
    input  logic [VAR_W-1:0] value_i,
    input  mode_e            mode_i,
    output logic             pass_o
);

    always_comb begin
        pass_o = 1'b0;
        case (mode_i)
            NONZERO: pass_o = |value_i;
            ZERO:    pass_o = ~|value_i;
            ODD:     pass_o = ^value_i;
            ONES:    pass_o = &value_i;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/constraint_eval_pipe.sv
// Two-stage constraint evaluator: S1 captures per-channel pass bits at acceptance,
// S2 reduces them to a verdict. The pipeline stalls as a whole on output backpressure.
module constraint_eval_pipe
    import constraint_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int VAR_W  = 32,
    parameter int CNT_W  = 16,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_ch,
    input  logic [MODE_W-1:0]       cfg_mode,
    input  logic                    clr_cnt,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*VAR_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat,
    output logic [IDX_W-1:0]        out_fail_idx,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt
);

    // Handshake: a beat moves on a rising edge where valid && ready are both high;
    // valid never depends on ready, and a presented verdict holds until consumed.

    mode_e             mode_q [NUM_CH];
    mode_e             mode_d [NUM_CH];
    logic              ready_en_q;
    logic              s1_valid_q, s1_valid_d;
    logic [NUM_CH-1:0] s1_pass_q, s1_pass_d;
    logic [NUM_CH-1:0] lane_pass;
    logic              out_valid_q, out_valid_d;
    logic              out_sat_q, out_sat_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [IDX_W-1:0]  fail_idx;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic              advance;
    logic              accept;
    logic              consume;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = ready_en_q && advance;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        constraint_lane #(
            .VAR_W (VAR_W)
        ) u_lane (
            .value_i (in_data[k*VAR_W +: VAR_W]),
            .mode_i  (mode_q[k]),
            .pass_o  (lane_pass[k])
        );
    end

    // Out-of-range channel numbers match no entry and are dropped.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            mode_d[k] = mode_q[k];
            if (cfg_we && (cfg_ch == IDX_W'(k))) begin
                mode_d[k] = mode_e'(cfg_mode);
            end
        end
    end

    always_comb begin
        fail_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!s1_pass_q[k]) begin
                fail_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_pass_d   = s1_pass_q;
        out_valid_d = out_valid_q;
        out_sat_d   = out_sat_q;
        out_idx_d   = out_idx_q;
        if (advance) begin
            s1_valid_d  = accept;
            s1_pass_d   = accept ? lane_pass : '0;
            out_valid_d = s1_valid_q;
            out_sat_d   = s1_valid_q && (&s1_pass_q);
            out_idx_d   = s1_valid_q ? fail_idx : '0;
        end
    end

    // Clear wins over a same-cycle consume; counters stick at all-ones.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (clr_cnt) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end else if (consume) begin
            if (out_sat_q) begin
                if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end else begin
                if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) mode_q[k] <= NONZERO;
            ready_en_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_pass_q   <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_idx_q   <= '0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) mode_q[k] <= mode_d[k];
            ready_en_q  <= 1'b1;
            s1_valid_q  <= s1_valid_d;
            s1_pass_q   <= s1_pass_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            out_idx_q   <= out_idx_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sat      = out_sat_q;
    assign out_fail_idx = out_idx_q;
    assign pass_cnt     = pass_cnt_q;
    assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_constraint_eval_pipe.sv
// Directed bench for constraint_eval_pipe with NUM_CH=4, VAR_W=8, CNT_W=4.
// Expected verdicts are queued at acceptance and checked by an independent monitor.
module tb_constraint_eval_pipe;

    localparam int NUM_CH = 4;
    localparam int VAR_W  = 8;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cfg_we = 1'b0;
    logic [IDX_W-1:0]        cfg_ch = '0;
    logic [1:0]              cfg_mode = '0;
    logic                    clr_cnt = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [NUM_CH*VAR_W-1:0] in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic                    out_sat;
    logic [IDX_W-1:0]        out_fail_idx;
    logic [CNT_W-1:0]        pass_cnt;
    logic [CNT_W-1:0]        fail_cnt;

    logic [2:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;
    int acc_cnt = 0;
    int cyc     = 0;
    bit stall_prev = 1'b0;
    logic [3:0] prev_out = '0;

    constraint_eval_pipe #(
        .NUM_CH (NUM_CH),
        .VAR_W  (VAR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .clr_cnt      (clr_cnt),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sat      (out_sat),
        .out_fail_idx (out_fail_idx),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: pops on every consumed verdict, checks stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) check("hold_stable", {28'd0, out_valid, out_sat, out_fail_idx}, {28'd0, prev_out});
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_verdict: got sat=%0b idx=%0d with nothing queued", out_sat, out_fail_idx);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    check("verdict", {29'd0, out_sat, out_fail_idx}, {29'd0, e});
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_valid, out_sat, out_fail_idx};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Driver tasks (inputs change 1 time unit after the rising edge)
    task automatic send(input logic [31:0] data, input logic exp_sat, input logic [1:0] exp_idx, input bit track);
        int waited = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && track) exp_q.push_back({exp_sat, exp_idx});
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        if (!acc) check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_with_cfg(input logic [31:0] data, input logic exp_sat, input logic [1:0] exp_idx,
                                 input logic [1:0] ch, input logic [1:0] mode);
        in_valid = 1'b1;
        in_data  = data;
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = mode;
        @(negedge clk);
        check("cfg_beat_accept", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({exp_sat, exp_idx});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic set_mode(input logic [1:0] ch, input logic [1:0] mode);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = mode;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (exp_q.size() != 0 && n < 100);
        check("drain", exp_q.size(), 32'd0);
    endtask

    task automatic check_cnts(input string name, input int p, input int f);
        check({name, "_pass_cnt"}, {28'd0, pass_cnt}, p);
        check({name, "_fail_cnt"}, {28'd0, fail_cnt}, f);
    endtask

    initial begin
        int c0;
        int snap;
        int stale;

        // Reset values
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_cnts("rst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

        // All NONZERO, two-cycle latency
        send(32'h01020304, 1'b1, 2'd0, 1'b1);
        @(negedge clk);
        check("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
        drain();
        check_cnts("first", 1, 0);

        // Failing patterns
        send(32'h05000700, 1'b0, 2'd0, 1'b1);
        send(32'h00010203, 1'b0, 2'd3, 1'b1);
        drain();
        check_cnts("fails", 1, 2);

        // Mode writes: the beat sharing the cycle of the ch2 write still sees NONZERO
        send_with_cfg(32'h01010101, 1'b1, 2'd0, 2'd2, 2'b11);
        set_mode(2'd0, 2'b01);
        send(32'h01FF0100, 1'b1, 2'd0, 1'b1);
        send(32'h01FE0100, 1'b0, 2'd2, 1'b1);
        send(32'h01FF0101, 1'b0, 2'd0, 1'b1);
        set_mode(2'd1, 2'b10);
        send(32'h01FF0300, 1'b0, 2'd1, 1'b1);
        send(32'h01FF0700, 1'b1, 2'd0, 1'b1);
        drain();
        check_cnts("modes", 4, 5);
        set_mode(2'd0, 2'b00);
        set_mode(2'd1, 2'b00);
        set_mode(2'd2, 2'b00);

        // Backpressure: 3 beats offered while out_ready is low for 5 cycles
        out_ready = 1'b0;
        snap = acc_cnt;
        fork
            begin
                send(32'h01010101, 1'b1, 2'd0, 1'b1);
                send(32'h01010001, 1'b0, 2'd1, 1'b1);
                send(32'h00010101, 1'b0, 2'd3, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("stall_accepts", acc_cnt - snap, 32'd2);
                out_ready = 1'b1;
            end
        join
        drain();
        check_cnts("stall", 5, 7);

        // Counter clear, saturation and full throughput
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check_cnts("clr_idle", 0, 0);
        c0 = cyc;
        for (int i = 0; i < 17; i++) send(32'h01010101, 1'b1, 2'd0, 1'b1);
        check("throughput_cycles", cyc - c0, 32'd17);
        drain();
        check_cnts("saturate", 15, 0);

        // Clear coinciding with a consume
        send(32'h01010101, 1'b1, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        check("coincide_valid", {31'd0, out_valid}, 32'd1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check_cnts("clr_consume", 0, 0);
        send(32'h01000101, 1'b0, 2'd2, 1'b1);
        drain();
        check_cnts("after_clr", 0, 1);

        // Reset with two beats in flight; mode table must return to NONZERO
        set_mode(2'd0, 2'b01);
        send(32'h01010101, 1'b0, 2'd0, 1'b0);
        send(32'h01010101, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_sat_idx", {29'd0, out_sat, out_fail_idx}, 32'd0);
        check_cnts("midrst", 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_rel_in_ready_high", {31'd0, in_ready}, 32'd1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_verdict", stale, 32'd0);
        send(32'h01010101, 1'b1, 2'd0, 1'b1);
        drain();
        check_cnts("post_rst", 1, 0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        n_total++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
